spi_master_ctrl: RTL

//  SPI master transaction sequencer for the SPI project. It runs one full-duplex transfer per start request.
//  - Internal SCLK half-period counter is programmed by 'fator'.
//  - Drives cs_n, sclk and mosi; samples miso.
//  - start/busy/done handshake towards the user logic.
//  - Fixed SPI mode 0: CPOL=0, CPHA=0.

---
 rtl/spi_master_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one full-duplex DATA_W-bit transfer per accepted start request.
// Optional macro SPI_LSB_FIRST_EN switches both shift directions to LSB first.
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIV_W-1:0]  fator,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  // Handshake: start is a level request sampled only in IDLE (accept = IDLE & start);
  // busy is high from the cycle after accept through HOLD; done pulses for one cycle
  // with rx_data valid, and rx_data then holds until the next done.
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_TRANSFER, S_HOLD, S_DONE
  } state_t;

  localparam int                TOG_W    = $clog2(2 * DATA_W + 1);
  localparam logic [TOG_W-1:0]  LAST_TOG = TOG_W'(2 * DATA_W - 1);

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    cnt;
  logic [DIV_W-1:0]    f_m1;
  logic [TOG_W-1:0]    tog;
  logic [DATA_W-1:0]   tx_sh, rx_sh;
  logic [DATA_W-1:0]   tx_shifted, rx_shifted;
  logic                first_bit, next_bit;
  logic                sclk_r, mosi_r;
  logic                tick, active;

`ifdef SPI_LSB_FIRST_EN
  assign first_bit  = tx_data[0];
  assign next_bit   = tx_sh[1];
  assign tx_shifted = tx_sh >> 1;
  assign rx_shifted = {miso, rx_sh[DATA_W-1:1]};
`else
  assign first_bit  = tx_data[DATA_W-1];
  assign next_bit   = tx_sh[DATA_W-2];
  assign tx_shifted = tx_sh << 1;
  assign rx_shifted = {rx_sh[DATA_W-2:0], miso};
`endif

  assign tick   = (cnt == f_m1);
  assign active = (state == S_SETUP) || (state == S_TRANSFER) || (state == S_HOLD);
  assign busy   = active;
  assign cs_n   = !active;
  assign done   = (state == S_DONE);
  assign sclk   = sclk_r;
  assign mosi   = mosi_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_SETUP;
      S_SETUP:    if (tick) state_nxt = S_TRANSFER;
      S_TRANSFER: if (tick && tog == LAST_TOG) state_nxt = S_HOLD;
      S_HOLD:     if (tick) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      f_m1    <= '0;
      tog     <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      sclk_r  <= 1'b0;
      mosi_r  <= 1'b0;
    end else begin
      if (!active || state != state_nxt || tick) cnt <= '0;
      else                                      cnt <= cnt + DIV_W'(1);

      case (state)
        S_IDLE: begin
          sclk_r <= 1'b0;
          mosi_r <= 1'b0;
          tog    <= '0;
          if (start) begin
            // A zero divider behaves like one so the bus never stalls.
            f_m1   <= (fator == '0) ? '0 : fator - DIV_W'(1);
            tx_sh  <= tx_data;
            rx_sh  <= '0;
            mosi_r <= first_bit;
          end
        end
        S_TRANSFER: begin
          if (tick) begin
            sclk_r <= !sclk_r;
            tog    <= tog + TOG_W'(1);
            if (!sclk_r) begin
              rx_sh <= rx_shifted;
            end else if (tog != LAST_TOG) begin
              tx_sh  <= tx_shifted;
              mosi_r <= next_bit;
            end
          end
        end
        S_HOLD: begin
          sclk_r <= 1'b0;
          if (tick) rx_data <= rx_sh;
        end
        S_DONE: begin
          sclk_r <= 1'b0;
          mosi_r <= 1'b0;
        end
        default: sclk_r <= 1'b0;
      endcase
    end
  end

endmodule
